demux1x2_deser: RTL
===================

# demux1x2_deser

Sequential 1-to-2 demultiplexer/deserializer: the receive-side counterpart of the `mux2x1` datapath. It accepts a serial bit stream with a per-bit channel select, assembles the bits for each channel into `WIDTH`-bit words, and presents each completed word on that channel's output with a valid/ready handshake. It sits downstream of `mux2x1` in the lab datapath, so a `mux2x1` + `demux1x2_deser` pair forms a loopback for bench self-checking.

## Interface
- `WIDTH`, default 2. Bits per assembled word. Legal range is 2..16.
- `clk`  input  1  Rising-edge clock; the only clock.
- `rst`  input  1  Reset. Synchronous, active-high.
- `in_valid`  input  1  A serial bit is offered this cycle.
- `in_ready`  output  1  The block accepts the offered bit this cycle.
- `sel`  input  1  Destination channel of the offered bit: 0 selects channel 0, 1 selects channel 1.
- `din`  input  1  The serial data bit.
- `out0_data`  output  WIDTH  Assembled word for channel 0.
- `out0_valid`  output  1  `out0_data` holds a complete word.
- `out0_ready`  input  1  The consumer takes the channel-0 word.
- `out1_data`, `out1_valid`, `out1_ready`  Same as channel 0, for channel 1.

## Operation
- **Acceptance:** a bit is accepted on a rising edge when `in_valid && in_ready`. The block samples `sel` and `din` only on accept.
- **Per-channel state:**
  - `shreg[WIDTH-1:0]` shift register.
  - `cnt` bit counter, range 0..WIDTH. Width is `$clog2(WIDTH+1)`.
  - `hold` output register with `vld` flag.
- **Bit order:** LSB first. The first accepted bit lands in bit 0 and the last in bit `WIDTH-1`.
- **Channel state machine** (encode in the `cnt` and `vld` values):
  - FILL: `cnt < WIDTH-1`. An accept shifts the bit in and increments `cnt`.
  - LAST: `cnt == WIDTH-1`. On accept, the full word moves to `hold`:
    - if `!vld`, or if `vld && outX_ready` in the same cycle: set `vld=1` and `cnt=0`;
    - otherwise: store the word in `shreg`, set `cnt=WIDTH`, and go to STALL.
  - STALL: `cnt == WIDTH`. When `outX_ready && vld`, `shreg` moves to `hold`, `vld` stays 1, and `cnt` returns to 0.
- **Ready:** `in_ready = (cnt[sel] != WIDTH)`. It is combinational from `sel`. Only the stalled channel back-pressures; bits for the other channel still flow.
- **Channel independence:** the channels are independent. An accept on one channel and a drain on the other in the same cycle both take effect.
- **Drain:** `outX_valid && outX_ready` clears `vld`, unless a new word is loaded in that same cycle.

## Timing
- **Reset:**
  - all `cnt=0`, `vld=0`, and `shreg`/`hold` cleared to 0;
  - `out0_valid = out1_valid = 0`, `out0_data = out1_data = 0`;
  - `in_ready = 1`.
- **Reset mid-word:** partially assembled bits and undrained words are discarded. Reset takes priority over every accept and drain in the same cycle.
- **Latency:** `outX_valid` rises on the edge that accepts the channel's `WIDTH`th bit, so the word is visible one cycle after that bit is offered.
- **Throughput:** a channel whose consumer holds `outX_ready=1` sustains one word every `WIDTH` accepts, with no bubble.
- **Output stability:** `outX_data` is registered and stays stable while `outX_valid && !outX_ready`.
- **Input handshake:** `in_valid` with `in_ready=0` has no effect. The producer keeps `sel`/`din` stable until the bit is accepted.

## Configuration
- **`DEMUX1X2_STATS_EN` defined:** adds outputs `word_cnt0` and `word_cnt1`, each 8 bits.
  - Each increments on every word drained from its channel and wraps 255 → 0.
  - Each resets to 0.
- **Macro undefined:** those ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- The shared package `demux_pkg` holds:
  - a `ch_state_t` enum (FILL/LAST/STALL) used for debug decode;
  - the `STATS_W = 8` constant.
- One sub-module, `deser_chan`, instantiated twice. It holds the per-channel shift register, counter, hold register and handshake.
- The top level does the `sel` steering and the `in_ready` mux.

## Test plan
- **Reset:** `rst=1` for 2 cycles → all valids 0, data 0, `in_ready=1`. Assert `rst` after one channel-0 bit, then send bits 1,1 → `out0_data=2'b11` with no stale bit.
- **Basic assembly (WIDTH=2):** with `out0_ready=1`, send `sel=0` bits 1 then 0 → `out0_valid=1` on the edge after the second bit, with `out0_data=2'b01`.
- **Interleave:** alternate `sel` 0,1,0,1 with din 1,0,0,1 → `out0_data=2'b01` and `out1_data=2'b10`, both valid in the same cycle.
- **Back-pressure:** hold `out1_ready=0` and send 4 bits on channel 1 → after the 4th bit `in_ready=0` for `sel=1` and 1 for `sel=0`. Then assert `out1_ready` for 2 cycles → both words drain in order.
- **Simultaneous events:** a channel-0 drain and a channel-0 last-bit accept in the same edge → `out0_valid` stays 1, the new word appears, and `cnt` goes to 0.
- **Stats (macro defined):** drain 256 channel-0 words → `word_cnt0` wraps to 0 and `word_cnt1` stays 0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: definitions shared by the demux1x2_deser slice.
//   ch_state_t : per-channel state (FILL/LAST/STALL), decoded from the bit
//                counter; drives the channel next-state logic and is handy
//                when looking at waveforms.
//   STATS_W    : width of the optional drained-word counters, which exist
//                only when DEMUX1X2_STATS_EN is defined.
package demux_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,   // collecting bits, more than one still missing
    LAST  = 2'd1,   // the next accepted bit completes the word
    STALL = 2'd2    // a full word waits in shreg behind an undrained hold
  } ch_state_t;

  localparam int STATS_W = 8;

endpackage

// File: rtl/deser_chan.sv
// deser_chan: one deserializer channel. It shifts accepted bits in LSB
// first, moves each completed word into a registered hold stage, and
// offers it with a valid/ready handshake. When hold is still occupied, a
// second completed word is parked in the shift register and the channel
// stops accepting bits until hold drains.
//
// Ports
//   clk, rst    clock and synchronous active-high reset
//   acc         a bit for this channel is accepted this cycle
//   din         the serial bit (sampled only when acc is high)
//   acc_ok      the channel can take a bit this cycle
//   out_data    registered word, stable while out_valid && !out_ready
//   out_valid   out_data holds a complete word
//   out_ready   the consumer takes the word this cycle
//   word_cnt    drained-word counter, wraps at 2**STATS_W
//               (present only with DEMUX1X2_STATS_EN defined)
module deser_chan
  import demux_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic             din,
  output logic             acc_ok,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef DEMUX1X2_STATS_EN
  ,
  output logic [STATS_W-1:0] word_cnt
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             vld, vld_n;
  logic [WIDTH-1:0] word;
  logic             drain;
  ch_state_t        state;

  always_comb begin
    if (cnt == CNT_FULL)      state = STALL;
    else if (cnt == CNT_LAST) state = LAST;
    else                      state = FILL;
  end

  // Bits enter at the top and move down, so after WIDTH shifts the first
  // bit sits in bit 0 (LSB first).
  assign word   = {din, shreg[WIDTH-1:1]};
  assign drain  = vld && out_ready;
  assign acc_ok = (state != STALL);

  always_comb begin
    cnt_n   = cnt;
    shreg_n = shreg;
    hold_n  = hold;
    vld_n   = vld && !out_ready;
    case (state)
      FILL: begin
        if (acc) begin
          shreg_n = word;
          cnt_n   = cnt + CW'(1);
        end
      end
      LAST: begin
        if (acc) begin
          // hold is free, or frees up this very edge: load straight in.
          if (!vld || out_ready) begin
            hold_n = word;
            vld_n  = 1'b1;
            cnt_n  = '0;
          end else begin
            shreg_n = word;
            cnt_n   = CNT_FULL;
          end
        end
      end
      STALL: begin
        if (drain) begin
          hold_n = shreg;
          vld_n  = 1'b1;
          cnt_n  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      vld   <= 1'b0;
      shreg <= '0;
      hold  <= '0;
    end else begin
      cnt   <= cnt_n;
      vld   <= vld_n;
      shreg <= shreg_n;
      hold  <= hold_n;
    end
  end

  assign out_data  = hold;
  assign out_valid = vld;

`ifdef DEMUX1X2_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)        word_cnt <= '0;
    else if (drain) word_cnt <= word_cnt + STATS_W'(1);
  end
`endif

endmodule

// File: rtl/demux1x2_deser.sv
// demux1x2_deser: sequential 1-to-2 demultiplexer / deserializer. Serial
// bits tagged with a channel select are steered to one of two deser_chan
// instances, each assembling WIDTH-bit words (LSB first) and presenting
// them with a valid/ready handshake. Only a stalled channel back-pressures;
// bits for the other channel keep flowing.
//
// Parameter
//   WIDTH       bits per word, 2..16
// Ports
//   clk, rst    clock and synchronous active-high reset
//   in_valid    a serial bit is offered
//   in_ready    the offered bit is accepted (combinational from sel)
//   sel         destination channel of the offered bit
//   din         the serial bit
//   out0_data/out0_valid/out0_ready   channel-0 word and handshake
//   out1_data/out1_valid/out1_ready   channel-1 word and handshake
//   word_cnt0/word_cnt1               drained-word counters (8 bit, wrap),
//                                     only with DEMUX1X2_STATS_EN defined
module demux1x2_deser
  import demux_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel,
  input  logic             din,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX1X2_STATS_EN
  ,
  output logic [STATS_W-1:0] word_cnt0,
  output logic [STATS_W-1:0] word_cnt1
`endif
);

  logic acc_ok0, acc_ok1;
  logic acc0, acc1;

  assign in_ready = sel ? acc_ok1 : acc_ok0;
  assign acc0     = in_valid && in_ready && !sel;
  assign acc1     = in_valid && in_ready &&  sel;

  deser_chan #(.WIDTH(WIDTH)) u_chan0 (
    .clk       (clk),
    .rst       (rst),
    .acc       (acc0),
    .din       (din),
    .acc_ok    (acc_ok0),
    .out_data  (out0_data),
    .out_valid (out0_valid),
    .out_ready (out0_ready)
`ifdef DEMUX1X2_STATS_EN
    ,
    .word_cnt  (word_cnt0)
`endif
  );

  deser_chan #(.WIDTH(WIDTH)) u_chan1 (
    .clk       (clk),
    .rst       (rst),
    .acc       (acc1),
    .din       (din),
    .acc_ok    (acc_ok1),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready)
`ifdef DEMUX1X2_STATS_EN
    ,
    .word_cnt  (word_cnt1)
`endif
  );

endmodule
